// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the IF stage: fetch FSM encoding, widths and reset constants.
package instruction_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 64;

    localparam logic [PC_W-1:0]    DEFAULT_RESET_PC  = 64'h0;
    localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'hD503201F;
    localparam logic [PC_W-1:0]    INSTR_BYTES       = 64'd4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    // 64-bit adder shared by the PC increment and the link-value computation
    function automatic logic [PC_W-1:0] alu_add(input logic [PC_W-1:0] a,
                                                input logic [PC_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: instruction, PC, PC+4 and valid, with load/flush/hold.
module if_id_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [PC_W-1:0]    link_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic [PC_W-1:0]    link_out,
    output logic               valid_out
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    link_q, link_d;
    logic               valid_q, valid_d;

    // Flush inserts a bubble and wins over load; otherwise the register holds
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        link_d  = link_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            pc_d    = '0;
            link_d  = '0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            link_d  = link_in;
            valid_d = 1'b1;
        end
    end

    // Register state; reset leaves a bubble in IF/ID
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            link_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            link_q  <= link_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pc_out    = pc_q;
    assign link_out  = link_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, keeps one request outstanding to instruction memory,
// buffers a response that lands during a decode stall, and squashes wrong-path
// fetches on a decode-resolved branch.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    PC_branch,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    PC_out_IF_ID,
    output logic [PC_W-1:0]    PC_branch_link,
    output logic               valid_IF_ID
);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    req_pc_q, req_pc_d;
    logic               drop_q, drop_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
    logic [PC_W-1:0]    buf_pc_q, buf_pc_d;

    logic               accept;
    logic               redirect;
    logic               ifid_load;
    logic               ifid_flush;
    logic [INSTR_W-1:0] ld_instr;
    logic [PC_W-1:0]    ld_pc;

    // Request depends only on state and the memory response, never on branch_taken
    assign imem_req  = !reset && ((state_q == ST_REQ) ||
                       ((state_q == ST_WAIT) && imem_valid && !drop_q && !stall));
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;
    assign redirect  = branch_taken && !stall;

    // Next-state, PC, drop and hold-buffer logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        drop_d      = drop_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ld_instr    = imem_rdata;
        ld_pc       = req_pc_q;

        if (accept) begin
            req_pc_d = pc_q;
            pc_d     = alu_add(pc_q, INSTR_BYTES);
        end

        if (redirect) begin
            // The target overrides the sequential increment; any response this cycle is squashed
            pc_d        = PC_branch;
            ifid_flush  = 1'b1;
            buf_instr_d = '0;
            buf_pc_d    = '0;
            if (accept || ((state_q == ST_WAIT) && !imem_valid)) begin
                drop_d  = 1'b1;
                state_d = ST_WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (accept) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else if (!stall) begin
                            ifid_load = 1'b1;
                            state_d   = accept ? ST_WAIT : ST_REQ;
                        end else begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = req_pc_q;
                            state_d     = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_load = 1'b1;
                        ld_instr  = buf_instr_q;
                        ld_pc     = buf_pc_q;
                        state_d   = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // Fetch control registers; reset may arrive mid-request and abandons it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            drop_q      <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            drop_q      <= drop_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clock     (clock),
        .reset     (reset),
        .load      (ifid_load),
        .flush     (ifid_flush),
        .instr_in  (ld_instr),
        .pc_in     (ld_pc),
        .link_in   (alu_add(ld_pc, INSTR_BYTES)),
        .instr_out (instruction),
        .pc_out    (PC_out_IF_ID),
        .link_out  (PC_branch_link),
        .valid_out (valid_IF_ID)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a variable-latency memory responder
// and queues of expected fetch addresses and expected IF/ID contents.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] PC_branch;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [63:0] PC_out_IF_ID;
    logic [63:0] PC_branch_link;
    logic        valid_IF_ID;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] exp_addr_q[$];
    logic [63:0] exp_pc_q[$];

    bit          mem_busy = 0;
    int          mem_rem  = 0;
    logic [63:0] mem_addr = '0;
    int          lat      = 1;
    logic        prev_v   = 1'b0;
    logic [63:0] prev_pc  = '0;

    instruction_fetch #(
        .RESET_PC  (64'h0),
        .NOP_INSTR (32'hD503201F)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .PC_branch      (PC_branch),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .instruction    (instruction),
        .PC_out_IF_ID   (PC_out_IF_ID),
        .PC_branch_link (PC_branch_link),
        .valid_IF_ID    (valid_IF_ID)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return 32'h8B000000 + a[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: memory drives response at negedge, accept is sampled
    // before the edge, IF/ID is scored just after the edge.
    task automatic tick();
        logic        acc;
        logic [63:0] acc_addr;
        logic [63:0] e;
        @(negedge clock);
        if (mem_busy && mem_rem > 0) mem_rem--;
        imem_valid = mem_busy && (mem_rem == 0);
        imem_rdata = imem_valid ? word_of(mem_addr) : 32'h0;
        #1;
        acc      = imem_req && imem_ready;
        acc_addr = imem_addr;
        if (imem_valid) mem_busy = 0;
        if (acc) begin
            mem_busy = 1;
            mem_rem  = lat;
            mem_addr = acc_addr;
            if (exp_addr_q.size() == 0) chk("accept_unexpected", {63'd0, acc}, 64'd0);
            else begin
                e = exp_addr_q.pop_front();
                chk("accept_addr", acc_addr, e);
            end
        end
        @(posedge clock);
        #2;
        if (valid_IF_ID && (!prev_v || PC_out_IF_ID != prev_pc)) begin
            if (exp_pc_q.size() == 0) chk("ifid_unexpected_load", {63'd0, valid_IF_ID}, 64'd0);
            else begin
                e = exp_pc_q.pop_front();
                chk("ifid_pc", PC_out_IF_ID, e);
                chk("ifid_instr", {32'd0, instruction}, {32'd0, word_of(e)});
                chk("ifid_link", PC_branch_link, e + 64'd4);
            end
        end
        prev_v  = valid_IF_ID;
        prev_pc = PC_out_IF_ID;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {63'd0, valid_IF_ID}, 64'd0);
        chk({tag, "_nop"}, {32'd0, instruction}, {32'd0, NOP});
    endtask

    initial begin
        reset        = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        PC_branch    = '0;
        imem_ready   = 1'b1;
        imem_valid   = 1'b0;
        imem_rdata   = '0;

        // Reset state
        tick();
        tick();
        chk_bubble("reset");
        chk("reset_pc_out", PC_out_IF_ID, 64'h0);
        chk("reset_link", PC_branch_link, 64'h0);
        chk("reset_req", {63'd0, imem_req}, 64'd0);
        reset = 1'b0;
        #1;
        chk("release_req", {63'd0, imem_req}, 64'd1);
        chk("release_addr", imem_addr, 64'h0);

        // Streaming with 1-cycle memory
        exp_addr_q.push_back(64'h0);
        exp_addr_q.push_back(64'h4);
        exp_addr_q.push_back(64'h8);
        exp_pc_q.push_back(64'h0);
        exp_pc_q.push_back(64'h4);
        tick();
        tick();
        chk("first_ifid_pc", PC_out_IF_ID, 64'h0);
        chk("first_link", PC_branch_link, 64'h4);
        chk("first_valid", {63'd0, valid_IF_ID}, 64'd1);
        tick();

        // Stall while the response for 8 returns; stalled branch must be ignored
        stall = 1'b1;
        tick();
        chk("stall1_pc", PC_out_IF_ID, 64'h4);
        chk("stall1_req", {63'd0, imem_req}, 64'd0);
        branch_taken = 1'b1;
        PC_branch    = 64'h300;
        tick();
        chk("stall_br_pc", PC_out_IF_ID, 64'h4);
        chk("stall_br_valid", {63'd0, valid_IF_ID}, 64'd1);
        chk("stall_br_addr", imem_addr, 64'hC);
        branch_taken = 1'b0;
        tick();
        chk("stall3_pc", PC_out_IF_ID, 64'h4);
        chk("stall3_req", {63'd0, imem_req}, 64'd0);
        stall = 1'b0;
        exp_pc_q.push_back(64'h8);
        tick();
        chk("unstall_pc", PC_out_IF_ID, 64'h8);
        chk("unstall_req", {63'd0, imem_req}, 64'd1);
        chk("unstall_addr", imem_addr, 64'hC);
        exp_addr_q.push_back(64'hC);
        tick();

        // Redirect while 0x10 is outstanding with 3-cycle latency
        lat = 3;
        exp_pc_q.push_back(64'hC);
        exp_addr_q.push_back(64'h10);
        tick();
        tick();
        branch_taken = 1'b1;
        PC_branch    = 64'h100;
        tick();
        chk_bubble("redir_wait");
        chk("redir_wait_addr", imem_addr, 64'h100);
        branch_taken = 1'b0;
        lat = 1;
        tick();
        chk_bubble("redir_drop");
        exp_addr_q.push_back(64'h100);
        tick();
        exp_pc_q.push_back(64'h100);
        exp_addr_q.push_back(64'h104);
        tick();

        // Redirect coinciding with an accept (of 0x108), then again with accept of 0x20
        branch_taken = 1'b1;
        PC_branch    = 64'h18;
        exp_addr_q.push_back(64'h108);
        tick();
        chk_bubble("redir_acc1");
        branch_taken = 1'b0;
        tick();
        chk_bubble("redir_acc1_drop");
        exp_addr_q.push_back(64'h18);
        tick();
        exp_addr_q.push_back(64'h1C);
        exp_pc_q.push_back(64'h18);
        tick();
        branch_taken = 1'b1;
        PC_branch    = 64'h200;
        exp_addr_q.push_back(64'h20);
        tick();
        chk_bubble("redir_acc20");
        branch_taken = 1'b0;
        tick();
        chk_bubble("redir_acc20_drop");
        exp_addr_q.push_back(64'h200);
        tick();
        lat = 4;
        exp_pc_q.push_back(64'h200);
        exp_addr_q.push_back(64'h204);
        tick();
        tick();

        // Asynchronous reset while 0x204 is outstanding
        reset      = 1'b1;
        imem_ready = 1'b0;
        #1;
        chk_bubble("async_rst");
        chk("async_rst_pc", PC_out_IF_ID, 64'h0);
        chk("async_rst_req", {63'd0, imem_req}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_req", {63'd0, imem_req}, 64'd1);
        chk("post_rst_addr", imem_addr, 64'h0);
        tick();
        chk("stale_ignored_valid", {63'd0, valid_IF_ID}, 64'd0);
        chk("stale_ignored_addr", imem_addr, 64'h0);
        imem_ready = 1'b1;
        lat = 1;
        exp_addr_q.push_back(64'h0);
        exp_addr_q.push_back(64'h4);
        exp_pc_q.push_back(64'h0);
        tick();
        tick();
        chk("restart_pc", PC_out_IF_ID, 64'h0);

        chk("addr_queue_drained", 64'(exp_addr_q.size()), 64'd0);
        chk("ifid_queue_drained", 64'(exp_pc_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
IF stage of the pipelined ARMv8 core: the producer end of the IF/ID interface that the decode stage consumes. It owns the PC and issues requests to a variable-latency instruction memory. It loads the IF/ID register (instruction, PC, PC+4) and honours the decode stall and the decode-resolved branch redirect, flushing wrong-path fetches.

Parameters:
RESET_PC, 64'h0, PC value fetched first after reset
NOP_INSTR, 32'hD503201F, bubble instruction placed in IF/ID on flush/reset

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard hold: IF/ID and PC must not advance
branch_taken  in  1  decode resolved a taken branch (cond/uncond/reg)
PC_branch  in  64  redirect target from decode (PC_mux)
imem_req  out  1  fetch request valid
imem_addr  out  64  fetch address
imem_ready  in  1  memory accepts request this cycle (req & ready = accept)
imem_valid  in  1  read data valid (exactly one per accepted request)
imem_rdata  in  32  instruction word
instruction  out  32  IF/ID instruction
PC_out_IF_ID  out  64  IF/ID PC of instruction
PC_branch_link  out  64  IF/ID PC+4 (BL link value)
valid_IF_ID  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, any state, including mid-request): pc=RESET_PC, state=REQ, drop=0, hold buffer empty; instruction=NOP_INSTR, PC_out_IF_ID=0, PC_branch_link=0, valid_IF_ID=0, imem_req=0 during reset; imem_req=1 from first cycle after release.
- At most one outstanding request. A response cycle may issue the next request in the same cycle, giving 1 instr/cycle with 1-cycle memory.
- imem_addr = pc; imem_req is a function of state only (REQ, or WAIT with imem_valid & !drop & !stall). It never depends combinationally on branch_taken.
- On accept: req_pc <= pc, pc <= pc+4 (64-bit wrap), state WAIT.
- States:
  REQ: req=1; accept -> WAIT.
  WAIT: await imem_valid. On valid & !drop & !stall: IF/ID <= {rdata, req_pc, req_pc+4, valid=1}; re-issue (accept -> WAIT, else REQ). On valid & !drop & stall: capture into hold buffer -> HOLD. On valid & drop: discard, drop<=0 -> REQ.
  HOLD: req=0; when !stall, IF/ID <= buffer -> REQ.
- Stall without response: IF/ID, pc and buffer hold; outstanding request still completes into the buffer.
- Redirect priority: reset > (branch_taken & !stall) > stall > normal. branch_taken is ignored while stall=1.
- Redirect: pc <= PC_branch (overrides +4, including an accept in the same cycle). IF/ID <= bubble (NOP_INSTR, valid=0). Hold buffer cleared.
- Redirect in flight: if a request is outstanding, or accepted this cycle, and no response is consumed this cycle, set drop=1 and go to WAIT. A response arriving in the redirect cycle is discarded. Otherwise go to REQ.
- Latency: accept at cycle N, valid at N+k -> IF/ID updated at edge ending N+k.

Decomposition:
- Shared package: fetch state encoding (REQ/WAIT/HOLD), NOP_INSTR, RESET_PC, instruction/PC width constants.
- Sub-module: if_id_register (instruction, PC, PC+4, valid; with load, flush and hold controls). The FSM and PC logic stay in instruction_fetch; PC+4 reuses alu_add.

Test Plan:
- Reset release, 1-cycle memory -> addresses 0,4,8,... one per cycle; IF/ID PC 0 one cycle after first valid; PC_branch_link=4; valid_IF_ID=1.
- Stall held 3 cycles while response to addr 8 returns -> IF/ID keeps PC 4; word for 8 buffered, no new req; after stall drops, IF/ID PC=8, next req addr 12.
- branch_taken with PC_branch=0x100 while request 0x10 outstanding with 3-cycle latency -> 0x10 data discarded; IF/ID bubble (NOP, valid=0); next accepted addr 0x100; IF/ID PC 0x100, link 0x104.
- branch_taken and stall both high -> redirect ignored; pc and IF/ID unchanged.
- Redirect in the same cycle as accept of addr 0x20 -> pc=PC_branch, drop=1, 0x20 response never enters IF/ID.
- Async reset asserted mid-WAIT -> outputs reset immediately (valid_IF_ID=0, NOP); late stale imem_valid after release is ignored; fetch restarts at RESET_PC.
